// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: core data memory; stores queue in a small FIFO and retire to a single-port word array.
// Latency: loads are combinational (0 cycles); stores reach the array on the first cycle the port is free.
// Backpressure: none to the core; a store to a full, non-draining buffer is dropped and flags sb_overflow_o.
// Build option SB_FORWARD_EN: merge pending stores into loads; otherwise loads see the array only and flag sb_hazard_o.
module dmem_store_buffer #(
    parameter int size        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int SB_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  logic                      rw_i,
    input  logic [size-1:0]           addr_i,
    input  logic [size-1:0]           wdata_i,
    input  logic [2:0]                ctrl_i,
    input  logic                      ext_busy_i,
    output logic [size-1:0]           rdata_o,
    output logic [$clog2(SB_DEPTH):0] sb_count_o,
    output logic                      sb_empty_o,
    output logic                      sb_overflow_o,
    output logic                      sb_hazard_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [31:0]   dat;
        logic [3:0]    mask;
    } sb_entry_t;

    sb_entry_t           sb_q [SB_DEPTH];
    logic [31:0]         mem_q [DEPTH_WORDS];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [PW:0]         count;
    logic                overflow_q;

    logic [AW-1:0]       idx;
    sb_entry_t           new_entry;
    sb_entry_t           head;
    logic                is_load, is_store, full, drain, push;
    logic [SB_DEPTH-1:0] hit;   // by age: bit 0 is the oldest pending entry
    logic [31:0]         word, lane;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic                unused_addr;

    assign idx         = addr_i[AW+1:2];
    assign unused_addr = ^addr_i[size-1:AW+2];

    assign is_load  = en_i & ~rw_i;
    assign is_store = en_i & rw_i;
    assign full     = (count == (PW+1)'(SB_DEPTH));
    assign drain    = (count != '0) & ~is_load & ~ext_busy_i;
    assign push     = is_store & (~full | drain);
    assign head     = sb_q[rd_ptr];

    // Store data is replicated across lanes; the mask alone selects the bytes written.
    always_comb begin
        new_entry.idx  = idx;
        new_entry.dat  = wdata_i[31:0];
        new_entry.mask = 4'b1111;
        case (ctrl_i[1:0])
            2'b00: begin
                new_entry.dat  = {4{wdata_i[7:0]}};
                new_entry.mask = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                new_entry.dat  = {2{wdata_i[15:0]}};
                new_entry.mask = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (drain) rd_ptr <= rd_ptr + 1'b1;
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (push & ~drain)
                count <= count + 1'b1;
            else if (drain & ~push)
                count <= count - 1'b1;
            if (is_store & ~push) overflow_q <= 1'b1;
        end
    end

    // Entry payloads and the array carry no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) sb_q[wr_ptr] <= new_entry;
        if (drain) begin
            for (int b = 0; b < 4; b++) begin
                if (head.mask[b]) mem_q[head.idx][8*b +: 8] <= head.dat[8*b +: 8];
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            hit[k] = ((PW+1)'(k) < count) && (sb_q[rd_ptr + PW'(k)].idx == idx);
        end
    end

`ifdef SB_FORWARD_EN
    // Walk oldest to youngest so the youngest pending byte wins.
    always_comb begin
        word = mem_q[idx];
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (hit[k]) begin
                for (int b = 0; b < 4; b++) begin
                    if (sb_q[rd_ptr + PW'(k)].mask[b])
                        word[8*b +: 8] = sb_q[rd_ptr + PW'(k)].dat[8*b +: 8];
                end
            end
        end
    end

    assign sb_hazard_o = 1'b0;
`else
    logic hazard_q;

    assign word = mem_q[idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hazard_q <= 1'b0;
        else if (is_load & (|hit))
            hazard_q <= 1'b1;
    end

    assign sb_hazard_o = hazard_q;
`endif

    always_comb begin
        byte_sel = word[{addr_i[1:0], 3'b000} +: 8];
        half_sel = addr_i[1] ? word[31:16] : word[15:0];
        lane     = word;
        case (ctrl_i[1:0])
            2'b00:   lane = ctrl_i[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   lane = ctrl_i[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: lane = word;
        endcase
    end

    assign rdata_o       = lane;
    assign sb_count_o    = count;
    assign sb_empty_o    = (count == '0);
    assign sb_overflow_o = overflow_q;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: randomized and directed stimulus against a queue-based reference model.
module tb_dmem_store_buffer;
    localparam int DEPTH_WORDS = 1024;
    localparam int SB_DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_i, rw_i, ext_busy_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic [2:0]  ctrl_i;
    logic [2:0]  sb_count_o;
    logic        sb_empty_o, sb_overflow_o, sb_hazard_o;

    dmem_store_buffer #(.size(32), .DEPTH_WORDS(DEPTH_WORDS), .SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk), .reset(reset), .en_i(en_i), .rw_i(rw_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .ctrl_i(ctrl_i), .ext_busy_i(ext_busy_i), .rdata_o(rdata_o),
        .sb_count_o(sb_count_o), .sb_empty_o(sb_empty_o),
        .sb_overflow_o(sb_overflow_o), .sb_hazard_o(sb_hazard_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic [31:0] dat;
        logic [3:0]  mask;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ref_mem [DEPTH_WORDS];
    bit          ref_ovf, ref_haz;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    endtask

    function automatic int unsigned widx(input logic [31:0] addr);
        return (addr >> 2) % DEPTH_WORDS;
    endfunction

    function automatic ent_t mk_entry(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] ctrl);
        ent_t e;
        int unsigned ln;
        e.idx = widx(addr);
        if (ctrl[1:0] == 2'b00) begin
            ln     = addr % 4;
            e.mask = 4'b0001 << ln;
            e.dat  = {24'h0, wdata[7:0]} << (8 * ln);
        end else if (ctrl[1:0] == 2'b01) begin
            ln     = (addr >> 1) % 2;
            e.mask = (ln == 1) ? 4'b1100 : 4'b0011;
            e.dat  = {16'h0, wdata[15:0]} << (16 * ln);
        end else begin
            e.mask = 4'hF;
            e.dat  = wdata;
        end
        return e;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] ctrl);
        logic [31:0] v;
        logic [7:0]  b;
        logic [15:0] h;
        v = ref_mem[widx(addr)];
`ifdef SB_FORWARD_EN
        foreach (q[i]) begin
            if (q[i].idx == widx(addr))
                for (int j = 0; j < 4; j++)
                    if (q[i].mask[j]) v[8*j +: 8] = q[i].dat[8*j +: 8];
        end
`endif
        b = 8'(v >> (8 * (addr % 4)));
        h = 16'(v >> (16 * ((addr >> 1) % 2)));
        case (ctrl)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return v;
        endcase
    endfunction

    // One clock: drive at negedge, check pre-edge outputs, then advance the model past the posedge.
    task automatic cyc(input bit en, input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ctrl, input bit busy);
        bit   ld, st, hitp;
        ent_t h;
        @(negedge clk);
        en_i = en; rw_i = rw; addr_i = addr; wdata_i = wdata; ctrl_i = ctrl; ext_busy_i = busy;
        #1;
        ld = en && !rw;
        st = en && rw;
        chk("count", 32'(sb_count_o), q.size());
        chk("empty", 32'(sb_empty_o), 32'(q.size() == 0));
        chk("overflow", 32'(sb_overflow_o), 32'(ref_ovf));
        chk("hazard", 32'(sb_hazard_o), 32'(ref_haz));
        if (ld) chk("rdata", rdata_o, ref_load(addr, ctrl));
        hitp = 0;
        foreach (q[i]) if (q[i].idx == widx(addr)) hitp = 1;
`ifndef SB_FORWARD_EN
        if (ld && hitp) ref_haz = 1;
`endif
        if (q.size() != 0 && !ld && !busy) begin
            h = q.pop_front();
            for (int j = 0; j < 4; j++)
                if (h.mask[j]) ref_mem[h.idx][8*j +: 8] = h.dat[8*j +: 8];
        end
        if (st) begin
            if (q.size() < SB_DEPTH) q.push_back(mk_entry(addr, wdata, ctrl));
            else ref_ovf = 1;
        end
    endtask

    task automatic idle(input bit busy);
        cyc(0, 0, 32'h0, 32'h0, 3'b010, busy);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        en_i = 0; rw_i = 0; ext_busy_i = 1;
        #2 reset = 0;
        #1;
        q.delete();
        ref_ovf = 0;
        ref_haz = 0;
        chk("rst_count", 32'(sb_count_o), q.size());
        chk("rst_empty", 32'(sb_empty_o), 32'(q.size() == 0));
        chk("rst_overflow", 32'(sb_overflow_o), 32'(ref_ovf));
        chk("rst_hazard", 32'(sb_hazard_o), 32'(ref_haz));
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  c;
        bit          rw;
        reset = 0; en_i = 0; rw_i = 0; addr_i = 0; wdata_i = 0; ctrl_i = 0; ext_busy_i = 0;
        ref_ovf = 0; ref_haz = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_count", 32'(sb_count_o), 32'd0);
        chk("reset_empty", 32'(sb_empty_o), 32'd1);
        chk("reset_overflow", 32'(sb_overflow_o), 32'd0);
        chk("reset_hazard", 32'(sb_hazard_o), 32'd0);
        @(negedge clk);
        reset = 1;

        // Prefill the word window used by every load; upper address bits must wrap.
        for (int w = 0; w < 16; w++)
            cyc(1, 1, ($urandom() & 32'hFFFF_F000) | (32'(w) << 2), $urandom(), 3'b010, 0);
        repeat (SB_DEPTH) idle(0);

        // Store then immediate load of the same word: the load blocks the drain.
        cyc(1, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
        cyc(1, 0, 32'h10, 32'h0, 3'b010, 0);
`ifdef SB_FORWARD_EN
        chk("fwd_word", rdata_o, 32'hDEADBEEF);
`endif
        repeat (2) idle(0);

        // Byte store over a known word, then byte/half loads with both extensions.
        cyc(1, 1, 32'h10, 32'h11223344, 3'b010, 0);
        repeat (2) idle(0);
        cyc(1, 1, 32'h13, 32'h00000080, 3'b000, 0);
        cyc(1, 0, 32'h13, 32'h0, 3'b000, 0);
        repeat (2) idle(0);
        cyc(1, 0, 32'h13, 32'h0, 3'b000, 0);
        chk("lb_sign", rdata_o, 32'hFFFFFF80);
        cyc(1, 0, 32'h13, 32'h0, 3'b100, 0);
        chk("lbu_zero", rdata_o, 32'h00000080);
        cyc(1, 0, 32'h12, 32'h0, 3'b001, 0);
        cyc(1, 0, 32'h12, 32'h0, 3'b101, 0);

        // Overflow: port held busy, one store more than the buffer holds.
        for (int i = 0; i < SB_DEPTH + 1; i++)
            cyc(1, 1, 32'h14 + 32'(4 * i), $urandom(), 3'b010, 1);
        idle(1);
        chk("ovf_count", 32'(sb_count_o), 32'(SB_DEPTH));
        chk("ovf_flag", 32'(sb_overflow_o), 32'd1);
        repeat (SB_DEPTH) idle(0);
        idle(0);
        chk("ovf_drained", 32'(sb_empty_o), 32'd1);

        // Reset in the middle of a drain; drained words keep their new values.
        for (int i = 0; i < SB_DEPTH; i++)
            cyc(1, 1, 32'h28 + 32'(4 * i), $urandom(), 3'b010, 1);
        repeat (2) idle(0);
        mid_reset();
        for (int i = 0; i < SB_DEPTH; i++)
            cyc(1, 0, 32'h28 + 32'(4 * i), 32'h0, 3'b010, 0);

        // Full buffer, free port: the store and a drain share the cycle.
        for (int i = 0; i < SB_DEPTH; i++)
            cyc(1, 1, 32'h04 + 32'(4 * i), $urandom(), 3'b010, 1);
        cyc(1, 1, 32'h3C, 32'hCAFEF00D, 3'b010, 0);
        idle(1);
        chk("full_pass_count", 32'(sb_count_o), 32'(SB_DEPTH));
        chk("full_pass_ovf", 32'(sb_overflow_o), 32'd0);
        repeat (SB_DEPTH + 1) idle(0);

        // Random traffic confined to the prefilled window.
        for (int n = 0; n < 3000; n++) begin
            a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            rw = ($urandom_range(0, 1) == 1);
            c  = rw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 9) < 8, rw, a, $urandom(), c, $urandom_range(0, 9) < 3);
        end
        repeat (SB_DEPTH + 1) idle(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
